// File: rtl/bcd_display_driver.sv
// Binary (0..511) to 3-digit BCD via iterative double-dabble, driving a
// time-multiplexed seven-segment display with optional leading-zero blanking.
module bcd_display_driver #(
  parameter int SCAN_DIV         = 50000,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ         = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  dataIn,
  output logic [6:0]  segOut,
  output logic [2:0]  digitEn,
  output logic [11:0] bcdOut,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t        state;
  logic [8:0]    captured_val;
  logic [20:0]   shift_reg;
  logic [20:0]   adjusted;
  logic [3:0]    iter_cnt;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    cur_nibble;
  logic          cur_blank;
  logic [2:0]    dig_raw;
  logic [6:0]    seg_code;
  logic [6:0]    seg_raw;

  assign fsm_state = state;

  // Double-dabble add-3 step on the three BCD nibbles above the binary field.
  always_comb begin
    adjusted        = shift_reg;
    adjusted[12:9]  = (shift_reg[12:9]  >= 4'd5) ? shift_reg[12:9]  + 4'd3 : shift_reg[12:9];
    adjusted[16:13] = (shift_reg[16:13] >= 4'd5) ? shift_reg[16:13] + 4'd3 : shift_reg[16:13];
    adjusted[20:17] = (shift_reg[20:17] >= 4'd5) ? shift_reg[20:17] + 4'd3 : shift_reg[20:17];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      captured_val <= 9'd0;
      shift_reg    <= 21'd0;
      iter_cnt     <= 4'd0;
      bcdOut       <= 12'h000;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dataIn != captured_val) begin
            captured_val <= dataIn;
            shift_reg    <= {12'b0, dataIn};
            iter_cnt     <= 4'd0;
            busy         <= 1'b1;
            state        <= CONVERT;
          end
        end
        CONVERT: begin
          shift_reg <= adjusted << 1;
          iter_cnt  <= iter_cnt + 4'd1;
          if (iter_cnt == 4'd8) state <= COMMIT;
        end
        COMMIT: begin
          bcdOut <= shift_reg[20:9];
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    cur_nibble = bcdOut[3:0];
    cur_blank  = 1'b0;
    dig_raw    = 3'b001;
    case (digit_idx)
      2'd1: begin
        cur_nibble = bcdOut[7:4];
        cur_blank  = BLANK_LZ && (bcdOut[11:8] == 4'd0) && (bcdOut[7:4] == 4'd0);
        dig_raw    = 3'b010;
      end
      2'd2: begin
        cur_nibble = bcdOut[11:8];
        cur_blank  = BLANK_LZ && (bcdOut[11:8] == 4'd0);
        dig_raw    = 3'b100;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (cur_nibble)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
    seg_raw = cur_blank ? 7'h00 : seg_code;
  end

  // Segments and enables share one register stage so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      segOut  <= {7{SEG_ACTIVE_LOW}};
      digitEn <= {3{DIGIT_ACTIVE_LOW}} ^ 3'b001;
    end else begin
      segOut  <= {7{SEG_ACTIVE_LOW}} ^ seg_raw;
      digitEn <= {3{DIGIT_ACTIVE_LOW}} ^ dig_raw;
    end
  end

endmodule

// File: doc/bcd_display_driver.md
Name: bcd_display_driver

Overview:
Downstream stage of the sequential mux: consumes its 9-bit dataOut and drives a 3-digit multiplexed seven-segment display.
- Converts the binary value (0..511) to three BCD digits with an iterative double-dabble engine, one shift per clock.
- Time-multiplexes the digits with a programmable scan divider and optional leading-zero blanking.

Parameters:
SCAN_DIV, 50000, clock cycles each digit stays enabled (>=2; benches use 4)
SEG_ACTIVE_LOW, 1, 1: segment outputs active-low; 0: active-high
DIGIT_ACTIVE_LOW, 1, 1: digit enables active-low; 0: active-high
BLANK_LZ, 1, 1: blank leading zero digits; 0: always show three digits

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
dataIn  input  9  binary value to display (mux dataOut)
segOut  output  7  segment drive {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
digitEn  output  3  digit enables, bit0 = units, bit1 = tens, bit2 = hundreds; one-hot active
bcdOut  output  12  committed BCD value {hundreds,tens,units}
busy  output  1  high while a conversion is in progress

Behaviour:
- Reset (clk edge with rst=1), regardless of state:
  - state=IDLE; capturedVal=0; bcdOut=12'h000; busy=0.
  - Scan counter=0; digit index=0 (units).
  - segOut=all segments off; digitEn=units enabled only.
  - Reset mid-conversion aborts it; the partial result is discarded.
- Conversion FSM, states IDLE, CONVERT, COMMIT:
  - IDLE: if dataIn != capturedVal, then capturedVal<=dataIn, load shift register {12'b0, dataIn}, iteration count=0, busy<=1, go to CONVERT. Otherwise stay in IDLE.
  - CONVERT: each cycle, add 3 to every BCD nibble >=5, then shift the whole 21-bit register left by 1. After the 9th shift, go to COMMIT.
  - COMMIT: bcdOut<=upper 12 bits of the shift register; busy<=0; go to IDLE.
  - Latency: if the change is sampled at edge N, busy rises at N, shifts occur at N+1..N+9, and bcdOut and busy=0 take effect at edge N+10.
  - dataIn changes while busy are ignored for the current conversion. The IDLE compare picks up the newest value on the cycle after COMMIT. No value is ever half-committed.
  - Back-to-back changes: the minimum spacing between commits is 11 cycles.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index advances 0->1->2->0.
- Outputs:
  - segOut and digitEn are registered on the same edge from the current index and bcdOut, so the two always change together (no ghosting). This adds one cycle of lag after an index change or a commit.
  - Segment encoding, active-high gfedcba: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Nibbles 10-15 (unreachable) encode as blank.
  - Polarity: output is inverted when SEG_ACTIVE_LOW=1; digitEn is inverted when DIGIT_ACTIVE_LOW=1.
- Blanking with BLANK_LZ=1:
  - Hundreds is blanked if its digit is 0.
  - Tens is blanked if hundreds=0 and tens=0.
  - Units is never blanked.
  - A blanked digit keeps its digitEn active but drives segOut all-off.
- Width: dataIn is at most 511, so the hundreds digit never exceeds 5; no overflow path exists.

Test Plan:
1. Reset (SCAN_DIV=4, defaults): hold rst 3 cycles -> bcdOut=000, busy=0, digitEn=3'b110, segOut=7'h7F. Release with dataIn=0 -> no conversion; busy stays 0.
2. dataIn 0->9'd237 -> busy high for exactly 10 cycles; bcdOut=12'h237 at N+10. Scan shows units=07, tens=4F, hundreds=5B (active-high, before inversion).
3. Max and boundary: dataIn=511 -> bcdOut=12'h511. Then dataIn=1 -> bcdOut=12'h001, with tens and hundreds blanked (segOut=7'h7F on those slots) and units showing 06.
4. Change during busy: dataIn=100, then 5 cycles later 42 -> first commit bcdOut=12'h100, second commit 12'h042 at the 11th cycle after the first. 100 is never replaced by a partial value.
5. Reset mid-conversion: dataIn=300, assert rst at cycle N+4 -> bcdOut=000, busy=0, state IDLE. After release, dataIn=300 reconverts to 12'h300.
6. Scan timing with BLANK_LZ=0, dataIn=5: each digitEn slot lasts exactly 4 cycles in order units, tens, hundreds. Tens and hundreds show 3F (zero, unblanked). segOut changes on the same edge as digitEn.
